// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, byte-strobed word array,
// response returned a fixed LATENCY edges after acceptance.
module dmem_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ReqValid,
    output logic                  o_ReqReady,
    input  logic                  i_ReqWrite,
    input  logic [31:0]           i_ReqAddr,
    input  logic [DATA_WIDTH-1:0] i_ReqWData,
    input  logic [3:0]            i_ReqStrb,
    output logic                  o_RespValid,
    input  logic                  i_RespReady,
    output logic [DATA_WIDTH-1:0] o_RespRData,
    output logic                  o_RespErr
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_badLatency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DATA_WIDTH != 32) begin : g_badDataWidth
        $error("dmem_responder: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_badAddrWidth
        $error("dmem_responder: ADDR_WIDTH must be in 1..29");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} StateT;

    StateT                 r_state;
    StateT                 w_nextState;
    logic [3:0]            r_count;
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_strb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    logic                  w_write;
    logic [31:0]           w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_strb;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_outOfRange;
    logic                  w_pairOk;
    logic                  w_err;
    logic                  w_enterResp;

    // With LATENCY=1 the RESP entry edge is the acceptance edge, so use live inputs.
    assign w_write      = (r_state == IDLE) ? i_ReqWrite : r_write;
    assign w_addr       = (r_state == IDLE) ? i_ReqAddr  : r_addr;
    assign w_wdata      = (r_state == IDLE) ? i_ReqWData : r_wdata;
    assign w_strb       = (r_state == IDLE) ? i_ReqStrb  : r_strb;
    assign w_index      = w_addr[ADDR_WIDTH+1:2];
    assign w_outOfRange = |(w_addr >> (ADDR_WIDTH + 2));

    always_comb begin
        w_pairOk = 1'b0;
        case (w_strb)
            4'b0001: w_pairOk = (w_addr[1:0] == 2'd0);
            4'b0010: w_pairOk = (w_addr[1:0] == 2'd1);
            4'b0100: w_pairOk = (w_addr[1:0] == 2'd2);
            4'b1000: w_pairOk = (w_addr[1:0] == 2'd3);
            4'b0011: w_pairOk = (w_addr[1:0] == 2'd0);
            4'b1100: w_pairOk = (w_addr[1:0] == 2'd2);
            4'b1111: w_pairOk = (w_addr[1:0] == 2'd0);
            default: w_pairOk = 1'b0;
        endcase
    end

    // Reads ignore the strobe unless the address is unaligned.
    assign w_err = w_outOfRange ||
                   (w_write ? !w_pairOk : ((w_addr[1:0] != 2'd0) && !w_pairOk));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_ReqValid) w_nextState = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (r_count == 4'd1) w_nextState = RESP;
            RESP:    if (i_RespReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_enterResp = i_rst_n && (w_nextState == RESP) && (r_state != RESP);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && i_ReqValid) begin
                r_write <= i_ReqWrite;
                r_addr  <= i_ReqAddr;
                r_wdata <= i_ReqWData;
                r_strb  <= i_ReqStrb;
                r_count <= 4'(LATENCY - 1);
            end else if (r_state == BUSY) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enterResp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_write) ? '0 : r_mem[w_index];
            end
        end
    end

    // Array contents survive reset; only a clean RESP entry commits a store.
    always_ff @(posedge i_clk) begin
        if (w_enterResp && !w_err && w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_ReqReady  = (r_state == IDLE) && i_rst_n;
    assign o_RespValid = (r_state == RESP);
    assign o_RespRData = r_rdata;
    assign o_RespErr   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 4, 1) share stimulus and are
// compared against a byte-level memory model built from the address/strobe rules.
module tb_dmem_responder;

    localparam int CLK_HALF = 5;
    localparam int WORDS    = 32;
    localparam int BYTES    = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic [3:0]  reqStrb;
    logic        respReady;
    logic [1:0]  sel;

    logic [2:0]  reqReadyV;
    logic [2:0]  respValidV;
    logic [2:0]  respErrV;
    logic [31:0] rdataV [3];

    logic        curReqReady;
    logic        curRespValid;
    logic        curRespErr;
    logic [31:0] curRData;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [3][WORDS];
    time         acceptTime;
    logic [31:0] lastRData;

    always #CLK_HALF clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(2)) u_dutLat2 (
        .i_clk(clk), .i_rst_n(rstN), .i_ReqValid(reqValid && (sel == 2'd0)),
        .o_ReqReady(reqReadyV[0]), .i_ReqWrite(reqWrite), .i_ReqAddr(reqAddr),
        .i_ReqWData(reqWData), .i_ReqStrb(reqStrb), .o_RespValid(respValidV[0]),
        .i_RespReady(respReady), .o_RespRData(rdataV[0]), .o_RespErr(respErrV[0])
    );

    dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(4)) u_dutLat4 (
        .i_clk(clk), .i_rst_n(rstN), .i_ReqValid(reqValid && (sel == 2'd1)),
        .o_ReqReady(reqReadyV[1]), .i_ReqWrite(reqWrite), .i_ReqAddr(reqAddr),
        .i_ReqWData(reqWData), .i_ReqStrb(reqStrb), .o_RespValid(respValidV[1]),
        .i_RespReady(respReady), .o_RespRData(rdataV[1]), .o_RespErr(respErrV[1])
    );

    dmem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LATENCY(1)) u_dutLat1 (
        .i_clk(clk), .i_rst_n(rstN), .i_ReqValid(reqValid && (sel == 2'd2)),
        .o_ReqReady(reqReadyV[2]), .i_ReqWrite(reqWrite), .i_ReqAddr(reqAddr),
        .i_ReqWData(reqWData), .i_ReqStrb(reqStrb), .o_RespValid(respValidV[2]),
        .i_RespReady(respReady), .o_RespRData(rdataV[2]), .o_RespErr(respErrV[2])
    );

    always_comb begin
        curReqReady  = reqReadyV[sel];
        curRespValid = respValidV[sel];
        curRespErr   = respErrV[sel];
        curRData     = rdataV[sel];
    end

    function automatic int latOf(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 4;
            default: return 1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Legal access = naturally aligned contiguous lane group of 1, 2 or 4 bytes.
    task automatic modelAccess(input int s, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] st,
                               output logic err, output logic [31:0] rd);
        int   off;
        int   size;
        int   word;
        logic legal;
        off   = int'(a[1:0]);
        size  = $countones(st);
        legal = 1'b0;
        if (size == 1 || size == 2 || size == 4) begin
            legal = ((off % size) == 0) && (st == 4'(((1 << size) - 1) << off));
        end
        err  = (a >= 32'(BYTES)) || (w ? !legal : ((off != 0) && !legal));
        rd   = '0;
        word = int'(a[6:2]);
        if (!err) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) model[s][word][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                rd = model[s][word];
            end
        end
    endtask

    task automatic selectDut(input logic [1:0] s);
        sel = s;
        @(negedge clk);
    endtask

    // Entered and left at a negedge; drives one request and consumes its response.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] st, input int hold, input logic keepReady);
        int          n;
        logic        expErr;
        logic [31:0] expData;
        logic [31:0] hRData;
        logic        hErr;
        respReady = keepReady;
        reqValid  = 1'b1;
        reqWrite  = w;
        reqAddr   = a;
        reqWData  = d;
        reqStrb   = st;
        n = 0;
        while (curReqReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("reqReadyTimeout", 32'(curReqReady), 32'd1);
        @(posedge clk);
        acceptTime = $time;
        modelAccess(int'(sel), w, a, d, st, expErr, expData);
        @(negedge clk);
        reqValid = 1'b0;
        reqWrite = 1'($urandom);
        reqAddr  = $urandom;
        reqWData = $urandom;
        reqStrb  = 4'($urandom);
        n = 1;
        while (curRespValid !== 1'b1 && n < 20) begin
            checkOutput("busyReqReady", 32'(curReqReady), 32'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 32'(n), 32'(latOf(sel)));
        checkOutput("respErr", 32'(curRespErr), 32'(expErr));
        checkOutput("respRData", curRData, expData);
        hRData    = curRData;
        hErr      = curRespErr;
        lastRData = curRData;
        for (int i = 0; i < hold; i++) begin
            respReady = 1'b0;
            @(negedge clk);
            checkOutput("bpValid", 32'(curRespValid), 32'd1);
            checkOutput("bpRData", curRData, hRData);
            checkOutput("bpErr", 32'(curRespErr), 32'(hErr));
            checkOutput("bpReqReady", 32'(curReqReady), 32'd0);
        end
        respReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("doneRespValid", 32'(curRespValid), 32'd0);
        checkOutput("doneReqReady", 32'(curReqReady), 32'd1);
        respReady = keepReady;
    endtask

    task automatic randomTxn(input int maxHold, input logic keepReady);
        logic        w;
        logic [31:0] a;
        logic [3:0]  st;
        int          sz;
        int          off;
        w = 1'($urandom);
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
        if ($urandom_range(0, 3) != 0) begin
            sz     = 1 << $urandom_range(0, 2);
            off    = $urandom_range(0, (4 / sz) - 1) * sz;
            st     = 4'(((1 << sz) - 1) << off);
            a[1:0] = 2'(off);
        end else begin
            st = 4'($urandom);
        end
        applyStimulus(w, a, $urandom, st, keepReady ? 0 : $urandom_range(0, maxHold), keepReady);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        logic [31:0] saved;
        time         prevAccept;
        logic [31:0] a;

        sel       = 2'd0;
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqWrite  = 1'b0;
        reqAddr   = '0;
        reqWData  = '0;
        reqStrb   = '0;
        respReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReqReady", 32'(reqReadyV), 32'd0);
        checkOutput("rstRespValid", 32'(respValidV), 32'd0);
        checkOutput("rstRespErr", 32'(respErrV), 32'd0);
        checkOutput("rstRData", rdataV[0] | rdataV[1] | rdataV[2], 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("postRstReqReady", 32'(reqReadyV), 32'h7);
        checkOutput("postRstRespValid", 32'(respValidV), 32'd0);

        // Fill every word so later reads have a defined reference.
        for (int s = 0; s < 3; s++) begin
            selectDut(2'(s));
            for (int w = 0; w < WORDS; w++) begin
                applyStimulus(1'b1, 32'(4 * w), $urandom, 4'hF, 0, 1'b0);
            end
        end

        selectDut(2'd0);
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);
        checkOutput("wordLoad", lastRData, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h8, 32'h11223344, 4'hF, 0, 1'b0);
        applyStimulus(1'b1, 32'h9, 32'h0000AA00, 4'b0010, 0, 1'b0);
        applyStimulus(1'b1, 32'hA, 32'hBBBB0000, 4'b1100, 1, 1'b0);
        applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0);
        checkOutput("mergeLoad", lastRData, 32'hBBBBAA44);
        applyStimulus(1'b1, 32'h81, 32'h12345678, 4'b0011, 0, 1'b0);
        applyStimulus(1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0);
        applyStimulus(1'b1, 32'h5, 32'h12345678, 4'b0011, 0, 1'b0);
        applyStimulus(1'b1, 32'hC, 32'h12345678, 4'b0000, 0, 1'b0);
        applyStimulus(1'b0, 32'h6, 32'h0, 4'b0001, 0, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b0);
        for (int i = 0; i < 40; i++) randomTxn(3, 1'b0);

        // Reset two edges into a LATENCY=4 store: the store must not land.
        selectDut(2'd1);
        saved    = model[1][1];
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h4;
        reqWData = 32'hCAFEF00D;
        reqStrb  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstRespValid", 32'(curRespValid), 32'd0);
        checkOutput("midRstReqReady", 32'(curReqReady), 32'd0);
        checkOutput("midRstRData", curRData, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("relReqReady", 32'(curReqReady), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("relRespValid", 32'(curRespValid), 32'd0);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0);
        checkOutput("midRstKeepOld", lastRData, saved);
        for (int i = 0; i < 15; i++) randomTxn(2, 1'b0);

        // LATENCY=1 back-to-back with RespReady held high.
        selectDut(2'd2);
        respReady  = 1'b1;
        prevAccept = 0;
        a          = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) a = 32'($urandom_range(0, WORDS - 1) * 4);
            applyStimulus((i % 2) == 0, a, $urandom, 4'hF, 0, 1'b1);
            if (i > 0) checkOutput("b2bPeriod", 32'(acceptTime - prevAccept), 32'(4 * CLK_HALF));
            prevAccept = acceptTime;
        end
        for (int i = 0; i < 20; i++) randomTxn(0, 1'b1);
        respReady = 1'b0;
        for (int i = 0; i < 10; i++) randomTxn(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
